// File: rtl/aes_scan_ctrl.sv
// aes_scan_ctrl
//   Bit-serial front end for the pipelined aes_128 core. Plaintext (and
//   optionally the key) is scanned in MSB first and held on the core inputs.
//   The block then waits the core's fixed latency, captures the ciphertext,
//   and scans it out LSB first.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting; key bits may be shifted, first plaintext bit -> LOAD
//   LOAD   | collecting plaintext bits (pauses allowed)
//   WAIT   | core inputs stable, counting down the pipeline latency
//   READY  | ciphertext captured, waiting for the first scan-out shift
//   UNLOAD | shifting ciphertext out (pauses allowed)
//
// Ports
//   CLK, rst           clock (posedge) and asynchronous active-high reset
//   scan_in_enable     shift scan_in_data into the register chosen by scan_in_sel
//   scan_in_data       serial input bit, MSB first
//   scan_in_sel        0: plaintext register, 1: key register
//   scan_out_enable    shift one ciphertext bit out
//   scan_out_data      serial output bit, LSB first, registered
//   aes_output         ciphertext from aes_128
//   aes_state, aes_key plaintext / key driven to aes_128
//   busy, done         registered state decodes (LOAD|WAIT, READY|UNLOAD)
//   overrun            sticky flag: scan-in attempted outside IDLE/LOAD
module aes_scan_ctrl #(
   parameter int           LATENCY   = 21,
   parameter logic [127:0] KEY_RESET = {128{1'b1}}
) (
   input  logic         CLK,
   input  logic         rst,
   input  logic         scan_in_enable,
   input  logic         scan_in_data,
   input  logic         scan_in_sel,
   input  logic         scan_out_enable,
   output logic         scan_out_data,
   input  logic [127:0] aes_output,
   output logic [127:0] aes_state,
   output logic [127:0] aes_key,
   output logic         busy,
   output logic         done,
   output logic         overrun
);

   localparam int             LW       = $clog2(LATENCY + 1);
   localparam logic [LW-1:0]  LAT_INIT = LW'(LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      WAIT   = 3'd2,
      READY  = 3'd3,
      UNLOAD = 3'd4
   } state_t;

   state_t        state;
   logic [127:0]  out_buf;
   logic [7:0]    bit_cnt;
   logic [LW-1:0] lat_cnt;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         aes_state     <= '0;
         aes_key       <= KEY_RESET;
         out_buf       <= '0;
         bit_cnt       <= '0;
         lat_cnt       <= '0;
         scan_out_data <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         // Output bit is only non-zero on the cycle right after a real shift.
         scan_out_data <= 1'b0;
         case (state)
            IDLE: begin
               if (scan_in_enable) begin
                  if (scan_in_sel) begin
                     aes_key <= {aes_key[126:0], scan_in_data};
                  end else begin
                     aes_state <= {aes_state[126:0], scan_in_data};
                     bit_cnt   <= 8'd1;
                     state     <= LOAD;
                     busy      <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (scan_in_enable) begin
                  if (scan_in_sel) begin
                     // Key must not change once a plaintext load has begun.
                     overrun <= 1'b1;
                  end else begin
                     aes_state <= {aes_state[126:0], scan_in_data};
                     if (bit_cnt == 8'd127) begin
                        bit_cnt <= '0;
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                     end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                     end
                  end
               end
            end
            WAIT: begin
               if (scan_in_enable) overrun <= 1'b1;
               // Entered with LATENCY-1, so the capture edge is LATENCY edges
               // after the edge that took the last plaintext bit.
               if (lat_cnt == '0) begin
                  out_buf <= aes_output;
                  state   <= READY;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            READY: begin
               if (scan_in_enable) overrun <= 1'b1;
               if (scan_out_enable) begin
                  scan_out_data <= out_buf[0];
                  out_buf       <= {1'b0, out_buf[127:1]};
                  bit_cnt       <= 8'd1;
                  state         <= UNLOAD;
               end
            end
            UNLOAD: begin
               if (scan_in_enable) overrun <= 1'b1;
               if (scan_out_enable) begin
                  scan_out_data <= out_buf[0];
                  out_buf       <= {1'b0, out_buf[127:1]};
                  if (bit_cnt == 8'd127) begin
                     bit_cnt <= '0;
                     state   <= IDLE;
                     done    <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
